// File: rtl/priority_code_decoder_pkg.sv
// Shared types and constants for the priority code decoder.
// State encoding, default code width and drop counter limit.
package prio_code_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  localparam int         CODE_W   = 2;
  localparam logic [7:0] DROP_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == DROP_MAX) ? v : v + 8'd1;
  endfunction

  // Counter load value for an n-cycle phase.
  function automatic logic [7:0] cnt_load(
    input int n
  );
    return (n > 0) ? 8'(n - 1) : 8'd0;
  endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO.
// Push is ignored when full, pop is ignored when empty.
module sync_fifo2 #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign full   = (r_cnt == 2'd2);
  assign empty  = (r_cnt == 2'd0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/priority_code_decoder.sv
// Replays buffered {V,Y} codes as held one-hot line pulses
// separated by forced idle gaps; counts dropped (V=0) codes.
module priority_code_decoder
  import prio_code_pkg::*;
#(
  parameter  int N     = CODE_W,
  parameter  int HOLD  = 4,
  parameter  int GAP   = 1,
  localparam int OUT_W = 2**N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_v,
  input  logic [N-1:0]     in_code,
  output logic [OUT_W-1:0] out_onehot,
  output logic             out_active,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  localparam logic [7:0] HOLD_LD = cnt_load(HOLD);
  localparam logic [7:0] GAP_LD  = cnt_load(GAP);

  logic             r_rdy_en;
  state_e           r_state;
  state_e           w_state_nx;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nx;
  logic [OUT_W-1:0] r_onehot;
  logic [OUT_W-1:0] w_onehot_nx;
  logic [OUT_W-1:0] w_dec;
  logic             r_active;
  logic [7:0]       r_drop;
  logic             w_xfer;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [N-1:0]     w_dout;

  // Ready is held low until the first edge after reset release.
  assign in_ready = r_rdy_en & ~w_full;
  assign w_xfer   = in_valid & in_ready;
  assign w_push   = w_xfer & in_v;
  assign w_drop   = w_xfer & ~in_v;

  sync_fifo2 #(
    .W (N)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (in_code),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_dec         = '0;
    w_dec[w_dout] = 1'b1;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_onehot_nx = r_onehot;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_onehot_nx = w_dec;
          w_cnt_nx    = HOLD_LD;
          w_state_nx  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nx = r_cnt - 8'd1;
        end else begin
          w_onehot_nx = '0;
          if (GAP > 0) begin
            w_cnt_nx   = GAP_LD;
            w_state_nx = S_GAP;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nx = r_cnt - 8'd1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_onehot_nx = '0;
        w_cnt_nx    = 8'd0;
        w_state_nx  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_onehot <= '0;
      r_active <= 1'b0;
      r_drop   <= 8'd0;
    end else begin
      r_rdy_en <= 1'b1;
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_onehot <= w_onehot_nx;
      r_active <= |w_onehot_nx;
      if (w_drop) begin
        r_drop <= sat_inc(r_drop);
      end
    end
  end

  assign out_onehot = r_onehot;
  assign out_active = r_active;
  assign busy       = (r_state != S_IDLE) | ~w_empty;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_priority_code_decoder.sv
// Bench for priority_code_decoder: timing-level reference model,
// scoreboard queue of expected pulses and a negedge monitor.
module tb_priority_code_decoder;

  localparam int N    = 2;
  localparam int OW   = 4;
  localparam int HOLD = 4;
  localparam int GAP  = 1;
  localparam int PER  = HOLD + GAP + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_v = 1'b0;
  logic [N-1:0]  in_code = '0;
  logic          in_ready;
  logic [OW-1:0] out_onehot;
  logic          out_active;
  logic          busy;
  logic [7:0]    drop_cnt;

  logic          in_valid5 = 1'b0;
  logic          in_v5 = 1'b0;
  logic [N-1:0]  in_code5 = '0;
  logic          in_ready5;
  logic [OW-1:0] out_onehot5;
  logic          out_active5;
  logic          busy5;
  logic [7:0]    drop_cnt5;

  priority_code_decoder #(
    .N    (N),
    .HOLD (HOLD),
    .GAP  (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_v       (in_v),
    .in_code    (in_code),
    .out_onehot (out_onehot),
    .out_active (out_active),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  priority_code_decoder #(
    .N    (N),
    .HOLD (1),
    .GAP  (0)
  ) dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid5),
    .in_ready   (in_ready5),
    .in_v       (in_v5),
    .in_code    (in_code5),
    .out_onehot (out_onehot5),
    .out_active (out_active5),
    .busy       (busy5),
    .drop_cnt   (drop_cnt5)
  );

  always #5 clk = ~clk;

  int ecount = 0;
  always @(posedge clk) ecount++;

  typedef struct {
    int s;
    int code;
  } exp_t;

  exp_t exp_q[$];
  int   occ_q[$];
  int   last_sched = -1000;
  int   last_pop   = -1000;
  int   rdy_edge   = 1 << 30;
  int   drop_m     = 0;
  bit   mon_en     = 1'b0;
  int   total      = 0;
  int   bad        = 0;
  bit   acc;
  int   s3;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at edge %0d",
               name, act, req, ecount);
    end
  endtask

  // Pulse of the scoreboard head is expected after edges s..s+HOLD-1.
  always @(negedge clk) begin
    if (mon_en) begin
      int e;
      int expv;
      e    = ecount;
      expv = 0;
      if (exp_q.size() > 0 && exp_q[0].s <= e)
        expv = 1 << exp_q[0].code;
      chk("onehot", int'(out_onehot), expv);
      chk("active", int'(out_active), int'(expv != 0));
      if (exp_q.size() > 0 && e >= exp_q[0].s + HOLD - 1)
        void'(exp_q.pop_front());
    end
  end

  task automatic step(input bit val, input bit v, input int code,
                      output bit a);
    int e;
    int t;
    int s;
    bit rdy_exp;
    bit busy_exp;
    e = ecount;
    while (occ_q.size() > 0 && occ_q[0] <= e) begin
      last_pop = occ_q[0];
      void'(occ_q.pop_front());
    end
    rdy_exp  = (e >= rdy_edge) && (occ_q.size() < 2);
    busy_exp = (occ_q.size() > 0) ||
               (e >= last_pop && e <= last_pop + HOLD + GAP - 1);
    chk("in_ready", int'(in_ready), int'(rdy_exp));
    chk("busy", int'(busy), int'(busy_exp));
    chk("drop_cnt", int'(drop_cnt), drop_m);
    in_valid = val;
    in_v     = v;
    in_code  = N'(code);
    a = val && in_ready;
    if (a) begin
      t = e + 1;
      if (v) begin
        s = (t + 1 > last_sched + PER) ? t + 1 : last_sched + PER;
        last_sched = s;
        occ_q.push_back(s);
        exp_q.push_back('{s, code});
      end else if (drop_m < 255) begin
        drop_m++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(1'b0, 1'b0, 0, a);
  endtask

  task automatic send(input bit v, input int code);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 50 && !a; i++) step(1'b1, v, code, a);
    if (!a) chk("send_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_onehot", int'(out_onehot), 0);
    chk("rst_active", int'(out_active), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_ready", int'(in_ready), 0);
    rst_n    = 1'b1;
    rdy_edge = ecount + 1;
    mon_en   = 1'b1;

    send(1'b1, 2);
    idle(12);

    send(1'b1, 0);
    send(1'b1, 1);
    send(1'b1, 3);
    send(1'b1, 2);
    idle(30);

    repeat (5) send(1'b0, $urandom_range(0, 3));
    idle(2);
    chk("drop5", int'(drop_cnt), 5);
    repeat (300) send(1'b0, $urandom_range(0, 3));
    idle(2);
    chk("drop_sat", int'(drop_cnt), 255);

    idle(20);
    send(1'b1, 3);
    s3 = last_sched;
    send(1'b1, 1);
    for (int i = 0; i < 30 && ecount < s3 + 1; i++) idle(1);
    chk("pre_rst_onehot", int'(out_onehot), 8);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_onehot", int'(out_onehot), 0);
    chk("arst_active", int'(out_active), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(in_ready), 0);
    @(negedge clk);
    exp_q.delete();
    occ_q.delete();
    last_sched = -1000;
    last_pop   = -1000;
    drop_m     = 0;
    rst_n      = 1'b1;
    rdy_edge   = ecount + 1;
    mon_en     = 1'b1;
    idle(12);
    send(1'b1, 0);
    idle(10);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 3), acc);
    end
    idle(30);
    chk("drain", exp_q.size(), 0);

    in_valid5 = 1'b1;
    in_v5     = 1'b1;
    in_code5  = 2'd1;
    @(negedge clk);
    chk("g0_ready", int'(in_ready5), 1);
    @(negedge clk);
    in_valid5 = 1'b0;
    chk("g0_p1", int'(out_onehot5), 2);
    @(negedge clk);
    chk("g0_idle", int'(out_onehot5), 0);
    @(negedge clk);
    chk("g0_p2", int'(out_onehot5), 2);
    chk("g0_act", int'(out_active5), 1);
    @(negedge clk);
    chk("g0_end", int'(out_onehot5), 0);
    chk("g0_busy", int'(busy5), 0);
    chk("g0_drop", int'(drop_cnt5), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
